// File: rtl/run_seq_ctrl_if.sv
// run_seq_ctrl_if: command handshake between the command source and the run sequencer
interface run_seq_ctrl_if #(parameter int LEN_W = 8);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_rej;
    modport master (output cmd_valid, cmd_op, cmd_len, input cmd_ready, cmd_rej);
    modport slave (input cmd_valid, cmd_op, cmd_len, output cmd_ready, cmd_rej);
endinterface

// File: rtl/run_seq_ctrl.sv
// run_seq_ctrl: IDLE/START/RUN/STOP sequencer with run counter and illegal-state recovery
module run_seq_ctrl #(
    parameter int LEN_W     = 8,
    parameter int START_CYC = 2,
    parameter int STOP_CYC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    run_seq_ctrl_if.slave    cmd,
    output logic [2:0]       state,
    output logic             busy,
    output logic             dp_en,
    output logic             dp_start,
    output logic             dp_done,
    output logic [LEN_W-1:0] run_cnt,
    input  logic             dbg_force,
    input  logic [2:0]       dbg_state,
    input  logic             err_clr,
    output logic             illegal_err
);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, RUN = 3'd2, STOP = 3'd3;
    localparam logic [1:0] OP_START = 2'b01, OP_STOP = 2'b10, OP_ABORT = 2'b11;
    localparam int TW = $clog2((START_CYC > STOP_CYC ? START_CYC : STOP_CYC) + 1);

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [LEN_W-1:0] len_q, len_d, run_cnt_q, run_cnt_d;
    logic             done_q, done_d, rej_q, rej_d, err_q, err_d;
    logic             legal, accept;

    // case rather than a range compare so X/Z codes also fall into the illegal path
    always_comb begin
        case (state_q)
            IDLE, START, RUN, STOP: legal = 1'b1;
            default:                legal = 1'b0;
        endcase
    end

    assign cmd.cmd_ready = legal & (state_q == IDLE | state_q == RUN);
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign busy          = legal & (state_q != IDLE);
    assign dp_en         = legal & (state_q == RUN);
    assign dp_start      = legal & (state_q == START) & (timer_q == '0);
    assign dp_done       = done_q;
    assign cmd.cmd_rej   = rej_q;
    assign state         = state_q;
    assign run_cnt       = run_cnt_q;
    assign illegal_err   = err_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        len_d     = len_q;
        run_cnt_d = run_cnt_q;
        done_d    = 1'b0;
        rej_d     = 1'b0;
        err_d     = err_q & ~err_clr;
        if (dbg_force) begin
            state_d = dbg_state;
            timer_d = '0;
        end else if (!legal) begin
            state_d   = IDLE;
            timer_d   = '0;
            run_cnt_d = '0;
            err_d     = 1'b1;
        end else if (state_q == IDLE) begin
            timer_d = '0;
            if (accept && cmd.cmd_op == OP_START) begin
                state_d = (cmd.cmd_len != '0) ? START : IDLE;
                len_d   = (cmd.cmd_len != '0) ? cmd.cmd_len : len_q;
                rej_d   = (cmd.cmd_len == '0);
            end
        end else if (state_q == START) begin
            state_d   = (timer_q == TW'(START_CYC - 1)) ? RUN : START;
            timer_d   = (state_d == RUN) ? '0 : timer_q + TW'(1);
            run_cnt_d = (state_d == RUN) ? '0 : run_cnt_q;
        end else if (state_q == RUN) begin
            // ABORT beats terminal count; STOP on the terminal cycle is one transition
            rej_d     = accept && cmd.cmd_op == OP_START;
            state_d   = (accept && cmd.cmd_op == OP_ABORT) ? IDLE :
                        (run_cnt_q == len_q - LEN_W'(1) || (accept && cmd.cmd_op == OP_STOP)) ? STOP : RUN;
            timer_d   = '0;
            run_cnt_d = (state_d == RUN) ? run_cnt_q + LEN_W'(1) : run_cnt_q;
        end else begin
            state_d = (timer_q == TW'(STOP_CYC - 1)) ? IDLE : STOP;
            done_d  = (state_d == IDLE);
            timer_d = done_d ? '0 : timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            len_q     <= '0;
            run_cnt_q <= '0;
            done_q    <= 1'b0;
            rej_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            len_q     <= len_d;
            run_cnt_q <= run_cnt_d;
            done_q    <= done_d;
            rej_q     <= rej_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_run_seq_ctrl.sv
// tb_run_seq_ctrl: directed stimulus with a cycle-stamped expectation scoreboard
module tb_run_seq_ctrl;
    typedef struct {
        int    cyc;
        string name;
        int    val;
    } chk_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       dbg_force, err_clr;
    logic [2:0] dbg_state, state;
    logic       busy, dp_en, dp_start, dp_done, illegal_err;
    logic [7:0] run_cnt;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    chk_t       q[$];

    run_seq_ctrl_if #(.LEN_W(8)) bus();

    run_seq_ctrl #(.LEN_W(8), .START_CYC(2), .STOP_CYC(2)) dut (
        .clk(clk), .rst(rst), .cmd(bus), .state(state), .busy(busy), .dp_en(dp_en),
        .dp_start(dp_start), .dp_done(dp_done), .run_cnt(run_cnt), .dbg_force(dbg_force),
        .dbg_state(dbg_state), .err_clr(err_clr), .illegal_err(illegal_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sig(string n);
        case (n)
            "state":       return int'(state);
            "busy":        return int'(busy);
            "dp_en":       return int'(dp_en);
            "dp_start":    return int'(dp_start);
            "dp_done":     return int'(dp_done);
            "run_cnt":     return int'(run_cnt);
            "illegal_err": return int'(illegal_err);
            "cmd_ready":   return int'(bus.cmd_ready);
            "cmd_rej":     return int'(bus.cmd_rej);
            default:       return -1;
        endcase
    endfunction

    task automatic want(input int c, input string n, input int v);
        q.push_back('{c, n, v});
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic issue_at(input int c, input logic [1:0] op, input logic [7:0] len);
        wait_to(c);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = 8'd0;
    endtask

    // Monitor: retire expectations due this cycle; strobes nobody expected are errors
    always @(negedge clk) begin
        bit s_start, s_done, s_rej;
        int act;
        s_start = 1'b0;
        s_done  = 1'b0;
        s_rej   = 1'b0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                act = sig(q[i].name);
                n_cmp++;
                if (q[i].cyc < cyc || act != q[i].val) begin
                    n_bad++;
                    $display("FAIL %s cycle %0d (now %0d): got %0d, want %0d", q[i].name, q[i].cyc, cyc, act, q[i].val);
                end
                if (q[i].name == "dp_start") s_start = 1'b1;
                if (q[i].name == "dp_done") s_done = 1'b1;
                if (q[i].name == "cmd_rej") s_rej = 1'b1;
                q.delete(i);
            end
        end
        if ((dp_start && !s_start) || (dp_done && !s_done) || (bus.cmd_rej && !s_rej)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_strobe cycle %0d: got start=%0d done=%0d rej=%0d, want none", cyc, dp_start, dp_done, bus.cmd_rej);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        logic [2:0] xv;
        bit ill;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_len = 8'd0;
        dbg_force = 1'b0;
        dbg_state = 3'd0;
        err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        s = cyc;
        want(s+1, "state", 0); want(s+1, "busy", 0); want(s+1, "dp_en", 0); want(s+1, "dp_start", 0);
        want(s+1, "dp_done", 0); want(s+1, "cmd_rej", 0); want(s+1, "run_cnt", 0);
        want(s+1, "illegal_err", 0); want(s+1, "cmd_ready", 1);
        @(negedge clk);
        rst = 1'b0;

        // START len=3: START 1-2, RUN 3-5, STOP 6-7, dp_done 8
        s = cyc + 2;
        want(s+1, "state", 1); want(s+1, "dp_start", 1); want(s+1, "cmd_ready", 0);
        want(s+2, "dp_start", 0); want(s+2, "cmd_ready", 0); want(s+2, "state", 1);
        want(s+3, "state", 2); want(s+3, "dp_en", 1); want(s+3, "run_cnt", 0); want(s+3, "cmd_ready", 1);
        want(s+4, "run_cnt", 1); want(s+5, "run_cnt", 2); want(s+5, "dp_en", 1);
        want(s+6, "state", 3); want(s+6, "dp_en", 0); want(s+6, "cmd_ready", 0); want(s+6, "run_cnt", 2);
        want(s+7, "cmd_ready", 0); want(s+7, "busy", 1);
        want(s+8, "dp_done", 1); want(s+8, "state", 0); want(s+8, "busy", 0); want(s+8, "cmd_ready", 1);
        want(s+9, "dp_done", 0);
        issue_at(s, 2'b01, 8'd3);
        wait_to(s+10);

        // START len=0 is rejected
        s = cyc + 2;
        want(s+1, "cmd_rej", 1); want(s+1, "state", 0); want(s+1, "dp_start", 0);
        want(s+1, "busy", 0); want(s+1, "cmd_ready", 1); want(s+2, "cmd_rej", 0);
        issue_at(s, 2'b01, 8'd0);
        wait_to(s+3);

        // len=10, START in RUN rejected, STOP at run_cnt=4
        s = cyc + 2;
        want(s+1, "state", 1); want(s+1, "dp_start", 1); want(s+3, "run_cnt", 0); want(s+3, "dp_en", 1);
        want(s+5, "cmd_rej", 1); want(s+5, "run_cnt", 2); want(s+6, "cmd_rej", 0); want(s+6, "run_cnt", 3);
        want(s+7, "dp_en", 1); want(s+7, "run_cnt", 4);
        want(s+8, "dp_en", 0); want(s+8, "state", 3); want(s+8, "run_cnt", 4);
        want(s+9, "dp_done", 0); want(s+10, "dp_done", 1); want(s+10, "state", 0);
        issue_at(s, 2'b01, 8'd10);
        issue_at(s+4, 2'b01, 8'd7);
        issue_at(s+7, 2'b10, 8'd0);
        wait_to(s+12);

        // len=5, ABORT at run_cnt=2: IDLE next cycle, no dp_done
        s = cyc + 2;
        want(s+1, "dp_start", 1); want(s+5, "run_cnt", 2);
        want(s+6, "state", 0); want(s+6, "dp_en", 0); want(s+6, "cmd_ready", 1);
        want(s+6, "busy", 0); want(s+6, "run_cnt", 2);
        for (int k = 6; k < 14; k++) want(s+k, "dp_done", 0);
        issue_at(s, 2'b01, 8'd5);
        issue_at(s+5, 2'b11, 8'd0);
        wait_to(s+14);

        // STOP on the terminal-count cycle: one transition, no reject
        s = cyc + 2;
        want(s+1, "dp_start", 1); want(s+5, "run_cnt", 2);
        want(s+6, "state", 3); want(s+6, "cmd_rej", 0); want(s+7, "state", 3);
        want(s+8, "dp_done", 1); want(s+8, "state", 0); want(s+9, "dp_done", 0);
        issue_at(s, 2'b01, 8'd3);
        issue_at(s+5, 2'b10, 8'd0);
        wait_to(s+10);

        // Inject 3'b101, re-inject, clear with set winning, then clear
        s = cyc + 2;
        want(s+1, "state", 5); want(s+1, "busy", 0); want(s+1, "dp_en", 0); want(s+1, "cmd_ready", 0);
        want(s+1, "dp_start", 0); want(s+1, "illegal_err", 0);
        want(s+2, "state", 0); want(s+2, "illegal_err", 1); want(s+2, "cmd_ready", 1);
        want(s+3, "state", 5); want(s+3, "illegal_err", 1);
        want(s+4, "state", 0); want(s+4, "illegal_err", 1);
        want(s+5, "illegal_err", 0);
        wait_to(s);
        dbg_force = 1'b1; dbg_state = 3'b101;
        @(negedge clk); dbg_force = 1'b0;
        @(negedge clk); dbg_force = 1'b1;
        @(negedge clk); dbg_force = 1'b0; err_clr = 1'b1;
        @(negedge clk);
        @(negedge clk); err_clr = 1'b0; dbg_state = 3'd0;

        // Inject 3'bx1x; a two-state simulator resolves it to some code, so expect from that
        s = cyc + 2;
        xv = 3'bx1x;
        ill = $isunknown(xv) || xv[2];
        if (ill) begin
            want(s+1, "cmd_ready", 0); want(s+1, "dp_en", 0);
            want(s+2, "illegal_err", 1); want(s+2, "state", 0);
        end else begin
            want(s+1, "state", int'(xv)); want(s+1, "dp_start", int'(xv == 3'd1));
        end
        want(s+3, "illegal_err", 0); want(s+3, "state", 0);
        wait_to(s);
        dbg_force = 1'b1; dbg_state = xv;
        @(negedge clk); dbg_force = 1'b0; dbg_state = 3'd0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // rst in RUN at run_cnt=3: reset values, no dp_done
        s = cyc + 2;
        want(s+1, "dp_start", 1); want(s+6, "run_cnt", 3); want(s+6, "dp_en", 1);
        want(s+7, "state", 0); want(s+7, "run_cnt", 0); want(s+7, "dp_en", 0);
        want(s+7, "illegal_err", 0); want(s+7, "busy", 0); want(s+7, "cmd_ready", 1);
        for (int k = 7; k < 15; k++) want(s+k, "dp_done", 0);
        issue_at(s, 2'b01, 8'd8);
        wait_to(s+6);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wait_to(s+15);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
